// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl: LFSR pattern source and MISR response compactor with pass/fail check for the s27 core
module s27_bist_ctrl #(
   parameter logic [7:0]  LFSR_SEED   = 8'h01,
   parameter int          N_PATTERNS  = 255,
   parameter int          CUT_RST_CYC = 2,
   parameter logic [15:0] GOLDEN      = 16'h0000
) (
   input  logic        CK,
   input  logic        RS,
   input  logic        start,
   input  logic        g17,
   output logic        g0,
   output logic        g1,
   output logic        g2,
   output logic        g3,
   output logic        cut_rs,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature
);
   typedef enum logic [1:0] {IDLE, INIT, APPLY, DONE} state_t;
   state_t      state, nxt;
   logic [7:0]  lfsr;
   logic [15:0] misr, pcnt;
   logic [3:0]  rcnt;
   logic        load, last_rst, last_pat, fb;
   assign load     = (state == IDLE || state == DONE) && start;
   assign last_rst = rcnt == 4'(CUT_RST_CYC - 1);
   assign last_pat = pcnt == 16'(N_PATTERNS - 1);
   assign fb       = misr[15] ^ g17;
   always_ff @(posedge CK)
      state <= RS ? IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: nxt = start ? INIT : state;
         INIT:       nxt = last_rst ? APPLY : INIT;
         APPLY:      nxt = last_pat ? DONE : APPLY;
         default:    nxt = IDLE;
      endcase
   end
   // Entering INIT (from IDLE or a DONE re-run) reloads the seed and clears the compactor.
   always_ff @(posedge CK) begin
      if (RS || load) begin
         lfsr <= LFSR_SEED;
         misr <= '0;
         pcnt <= '0;
         rcnt <= '0;
      end else if (state == INIT) begin
         rcnt <= rcnt + 4'd1;
      end else if (state == APPLY) begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         misr <= {misr[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         pcnt <= pcnt + 16'd1;
      end
   end
   always_comb begin
      {g3, g2, g1, g0} = state == APPLY ? lfsr[3:0] : 4'h0;
      cut_rs    = state == IDLE || state == INIT;
      busy      = state == INIT || state == APPLY;
      done      = state == DONE;
      pass      = state == DONE && misr == GOLDEN;
      signature = misr;
   end
endmodule

// File: tb/tb_s27_bist_ctrl.sv
// tb_s27_bist_ctrl: directed checks of the BIST wrapper with tied, pulsed and real s27 responses
module tb_s27_bist_ctrl;
   logic        CK = 1'b0;
   logic        RS, start, start_b, g17_b, sel;
   logic        g0, g1, g2, g3, cut_rs, busy, done, pass;
   logic [15:0] signature;
   logic        b0, b1, b2, b3, cut_rs_b, busy_b, done_b, pass_b;
   logic [15:0] signature_b;
   logic        s5, s6, s7, c8, c9, c10, c11, c12, c13, c14, c15, c16, core_g17;
   int          n_chk = 0, n_fail = 0;
   int          n;
   logic        busy_drop;
   logic [15:0] expv;
   logic [3:0]  gexp [4];

   always #5 CK = ~CK;

   s27_bist_ctrl u0 (
      .CK(CK), .RS(RS), .start(start), .g17(sel ? core_g17 : 1'b0),
      .g0(g0), .g1(g1), .g2(g2), .g3(g3), .cut_rs(cut_rs), .busy(busy),
      .done(done), .pass(pass), .signature(signature)
   );

   s27_bist_ctrl #(.N_PATTERNS(2)) u1 (
      .CK(CK), .RS(RS), .start(start_b), .g17(g17_b),
      .g0(b0), .g1(b1), .g2(b2), .g3(b3), .cut_rs(cut_rs_b), .busy(busy_b),
      .done(done_b), .pass(pass_b), .signature(signature_b)
   );

   // ISCAS89 s27 netlist driven by u0, flops cleared by cut_rs
   assign c14 = ~g0;
   assign c8  = c14 & s6;
   assign c12 = ~(g1 | s7);
   assign c15 = c12 | c8;
   assign c16 = g3 | c8;
   assign c9  = ~(c16 & c15);
   assign c11 = ~(s5 | c9);
   assign c10 = ~(c14 | c11);
   assign c13 = ~(g2 | c12);
   assign core_g17 = ~c11;
   always @(posedge CK)
      if (cut_rs) {s5, s6, s7} <= 3'b000;
      else        {s5, s6, s7} <= {c10, c11, c13};

   // Reference: LFSR + s27 + MISR over n patterns from a freshly reset core
   function automatic logic [15:0] ref_sig(input int np);
      logic [7:0]  l = 8'h01;
      logic [15:0] m = 16'h0000;
      logic        r5 = 1'b0, r6 = 1'b0, r7 = 1'b0;
      logic        a8, a9, a10, a11, a12, a13, a14, a15, a16;
      for (int i = 0; i < np; i++) begin
         a14 = ~l[0];
         a8  = a14 & r6;
         a12 = ~(l[1] | r7);
         a15 = a12 | a8;
         a16 = l[3] | a8;
         a9  = ~(a16 & a15);
         a11 = ~(r5 | a9);
         a10 = ~(a14 | a11);
         a13 = ~(l[2] | a12);
         m   = (m << 1) ^ ({16{m[15] ^ ~a11}} & 16'h1021);
         {r5, r6, r7} = {a10, a11, a13};
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      return m;
   endfunction

   task automatic tick;
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
      n_chk++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   initial begin
      RS = 1'b1; start = 1'b0; start_b = 1'b0; g17_b = 1'b0; sel = 1'b0;
      gexp[0] = 4'h2; gexp[1] = 4'h4; gexp[2] = 4'h8; gexp[3] = 4'h1;
      tick; tick;
      chk("rst_cut_rs", 16'(cut_rs), 16'd1);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_pass", 16'(pass), 16'd0);
      chk("rst_sig", signature, 16'h0000);
      chk("rst_g", 16'({g3, g2, g1, g0}), 16'h0);
      RS = 1'b0;
      // Defaults, g17 tied low
      start = 1'b1; tick; start = 1'b0;
      chk("c1_busy", 16'(busy), 16'd1);
      chk("c1_cut_rs", 16'(cut_rs), 16'd1);
      tick;
      chk("c2_cut_rs", 16'(cut_rs), 16'd1);
      chk("c2_g", 16'({g3, g2, g1, g0}), 16'h0);
      tick;
      chk("c3_cut_rs", 16'(cut_rs), 16'd0);
      chk("c3_g", 16'({g3, g2, g1, g0}), 16'h1);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("c4_7_g", 16'({g3, g2, g1, g0}), 16'(gexp[i]));
      end
      for (int c = 8; c <= 257; c++) tick;
      chk("c257_done", 16'(done), 16'd0);
      tick;
      chk("c258_done", 16'(done), 16'd1);
      chk("c258_busy", 16'(busy), 16'd0);
      chk("tie0_sig", signature, 16'h0000);
      chk("tie0_pass", 16'(pass), 16'd1);
      chk("done_cut_rs", 16'(cut_rs), 16'd0);
      // N_PATTERNS=2, g17 high only on the first APPLY cycle
      start_b = 1'b1; tick; start_b = 1'b0;
      tick; tick;
      g17_b = 1'b1; tick; g17_b = 1'b0;
      chk("n2_sig1", signature_b, 16'h1021);
      chk("n2_busy", 16'(busy_b), 16'd1);
      tick;
      chk("n2_done", 16'(done_b), 16'd1);
      chk("n2_sig", signature_b, 16'h2042);
      chk("n2_pass", 16'(pass_b), 16'd0);
      // Real s27 core, two runs back to back
      sel = 1'b1;
      expv = ref_sig(255);
      for (int run = 0; run < 2; run++) begin
         start = 1'b1; tick; start = 1'b0;
         chk("core_init_sig", signature, 16'h0000);
         n = 1;
         while (!done && n < 400) begin tick; n++; end
         chk("core_done_cycle", 16'(n), 16'd258);
         chk("core_sig", signature, expv);
         chk("core_pass", 16'(pass), 16'(expv == 16'h0000));
         tick; tick;
         chk("core_frozen", signature, expv);
      end
      // Reset at APPLY cycle 10
      start = 1'b1; tick; start = 1'b0;
      for (int i = 0; i < 11; i++) tick;
      chk("mid_sig", signature, ref_sig(9));
      RS = 1'b1; tick; RS = 1'b0;
      chk("mid_cut_rs", 16'(cut_rs), 16'd1);
      chk("mid_busy", 16'(busy), 16'd0);
      chk("mid_done", 16'(done), 16'd0);
      chk("mid_sig_clr", signature, 16'h0000);
      chk("mid_g", 16'({g3, g2, g1, g0}), 16'h0);
      tick;
      chk("mid_idle_busy", 16'(busy), 16'd0);
      // start held high throughout
      start = 1'b1; tick;
      n = 1; busy_drop = 1'b0;
      while (!done && n < 400) begin
         busy_drop |= !busy;
         tick; n++;
      end
      chk("hold_done_cycle", 16'(n), 16'd258);
      chk("hold_busy_drop", 16'(busy_drop), 16'd0);
      chk("hold_sig", signature, expv);
      tick;
      chk("hold_rerun_busy", 16'(busy), 16'd1);
      chk("hold_rerun_cut_rs", 16'(cut_rs), 16'd1);
      chk("hold_rerun_done", 16'(done), 16'd0);
      start = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
